// File: rtl/run_controller.sv
// Run/reset sequencer for the processor core: holds the core in reset after start,
// then grants clock-enabled cycles in free-run, bounded or single-step mode.
module run_controller #(
    parameter int CNT_W      = 32,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] limit,
    input  logic             step,
    input  logic             halt,
    input  logic             abort,
    output logic             core_rst,
    output logic             core_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             busy,
    output logic             done,
    output logic [1:0]       done_cause
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LIMIT_DEF = CNT_W'(MAX_CYCLES);

    localparam logic [1:0] MODE_FREE    = 2'b00;
    localparam logic [1:0] MODE_BOUNDED = 2'b01;
    localparam logic [1:0] MODE_STEP    = 2'b10;
    localparam logic [1:0] MODE_ALIAS   = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_LIMIT = 2'b01;
    localparam logic [1:0] CAUSE_HALT  = 2'b10;
    localparam logic [1:0] CAUSE_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RESET_HOLD = 3'd1,
        S_RUN        = 3'd2,
        S_STEP_WAIT  = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [1:0]         mode_r, mode_s;
    logic [CNT_W-1:0]   limit_r, limit_s;
    logic [HOLD_W-1:0]  hold_r, hold_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               step_q_r;
    logic               core_rst_r, core_rst_s;
    logic               core_en_r, core_en_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [1:0]         cause_r, cause_s;
    logic [1:0]         stop_cause_s;
    logic               step_rise_s;
    logic [CNT_W-1:0]   cnt_adv_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_SAT) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    assign step_rise_s = step & ~step_q_r;
    // The edge that ends an enabled cycle always counts it, even if it also stops the run.
    assign cnt_adv_s   = core_en_r ? sat_inc(cnt_r) : cnt_r;

    // Stop arbitration: abort > halt > limit, each only in the states that honour it.
    always_comb begin
        stop_cause_s = CAUSE_NONE;
        case (state_r)
            S_RESET_HOLD: begin
                if (abort) begin
                    stop_cause_s = CAUSE_ABORT;
                end else begin
                    stop_cause_s = CAUSE_NONE;
                end
            end
            S_RUN: begin
                if (abort) begin
                    stop_cause_s = CAUSE_ABORT;
                end else if (halt) begin
                    stop_cause_s = CAUSE_HALT;
                end else if ((mode_r == MODE_BOUNDED) && (cnt_adv_s == limit_r)) begin
                    stop_cause_s = CAUSE_LIMIT;
                end else begin
                    stop_cause_s = CAUSE_NONE;
                end
            end
            S_STEP_WAIT: begin
                if (abort) begin
                    stop_cause_s = CAUSE_ABORT;
                end else if (halt) begin
                    stop_cause_s = CAUSE_HALT;
                end else begin
                    stop_cause_s = CAUSE_NONE;
                end
            end
            default: stop_cause_s = CAUSE_NONE;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        limit_s    = limit_r;
        hold_s     = hold_r;
        cnt_s      = cnt_r;
        core_rst_s = core_rst_r;
        core_en_s  = 1'b0;
        cause_s    = cause_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_s    = S_RESET_HOLD;
                    mode_s     = (mode == MODE_ALIAS) ? MODE_FREE : mode;
                    limit_s    = (limit == '0) ? LIMIT_DEF : limit;
                    hold_s     = HOLD_LOAD;
                    cnt_s      = '0;
                    cause_s    = CAUSE_NONE;
                    core_rst_s = 1'b1;
                end else begin
                    core_rst_s = (state_r == S_IDLE);
                end
            end
            S_RESET_HOLD: begin
                hold_s = hold_r - HOLD_ONE;
                if (stop_cause_s != CAUSE_NONE) begin
                    state_s    = S_DONE;
                    cause_s    = stop_cause_s;
                    core_rst_s = 1'b0;
                end else if (hold_r == HOLD_ONE) begin
                    core_rst_s = 1'b0;
                    if (mode_r == MODE_STEP) begin
                        state_s = S_STEP_WAIT;
                    end else begin
                        state_s   = S_RUN;
                        core_en_s = 1'b1;
                    end
                end else begin
                    core_rst_s = 1'b1;
                end
            end
            S_RUN, S_STEP_WAIT: begin
                cnt_s = cnt_adv_s;
                if (stop_cause_s != CAUSE_NONE) begin
                    state_s    = S_DONE;
                    cause_s    = stop_cause_s;
                    core_rst_s = 1'b0;
                end else if (state_r == S_RUN) begin
                    core_en_s = 1'b1;
                end else begin
                    core_en_s = step_rise_s;
                end
            end
            default: begin
                state_s    = S_IDLE;
                cnt_s      = '0;
                cause_s    = CAUSE_NONE;
                core_rst_s = 1'b1;
            end
        endcase
        busy_s = (state_s == S_RESET_HOLD) || (state_s == S_RUN) || (state_s == S_STEP_WAIT);
        done_s = (state_s == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            mode_r     <= MODE_FREE;
            limit_r    <= '0;
            hold_r     <= '0;
            cnt_r      <= '0;
            step_q_r   <= 1'b0;
            core_rst_r <= 1'b1;
            core_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cause_r    <= CAUSE_NONE;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            limit_r    <= limit_s;
            hold_r     <= hold_s;
            cnt_r      <= cnt_s;
            step_q_r   <= step;
            core_rst_r <= core_rst_s;
            core_en_r  <= core_en_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            cause_r    <= cause_s;
        end
    end

    assign core_rst   = core_rst_r;
    assign core_en    = core_en_r;
    assign cycle_cnt  = cnt_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign done_cause = cause_r;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: a run-level behavioural model checked every
// cycle on two instances (defaults, and CNT_W=4/RST_CYCLES=1), plus literal checks.
module tb_run_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 1'b0, a_step = 1'b0, a_halt = 1'b0, a_abort = 1'b0;
    logic [1:0]  a_mode  = 2'd0;
    logic [31:0] a_limit = 32'd0;
    logic        a_core_rst, a_core_en, a_busy, a_done;
    logic [31:0] a_cycle_cnt;
    logic [1:0]  a_done_cause;

    logic        b_start = 1'b0, b_step = 1'b0, b_halt = 1'b0, b_abort = 1'b0;
    logic [1:0]  b_mode  = 2'd0;
    logic [3:0]  b_limit = 4'd0;
    logic        b_core_rst, b_core_en, b_busy, b_done;
    logic [3:0]  b_cycle_cnt;
    logic [1:0]  b_done_cause;

    run_controller dut_a (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .limit(a_limit),
        .step(a_step), .halt(a_halt), .abort(a_abort),
        .core_rst(a_core_rst), .core_en(a_core_en), .cycle_cnt(a_cycle_cnt),
        .busy(a_busy), .done(a_done), .done_cause(a_done_cause)
    );

    run_controller #(.CNT_W(4), .RST_CYCLES(1), .MAX_CYCLES(59)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .limit(b_limit),
        .step(b_step), .halt(b_halt), .abort(b_abort),
        .core_rst(b_core_rst), .core_en(b_core_en), .cycle_cnt(b_cycle_cnt),
        .busy(b_busy), .done(b_done), .done_cause(b_done_cause)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Run-level model: whether a run is active/stopped, edges since start, enabled-cycle count.
    typedef struct {
        bit     started;
        bit     stopped;
        bit     stepq;
        bit     en;
        int     es;
        int     mode;
        int     cause;
        longint cnt;
        longint lim;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_step(mdl_t m, bit st, logic [1:0] md, longint lim_in,
                                      bit stp, bit hlt, bit abt, int r, longint maxc, longint maxv);
        mdl_t n;
        bit   rise;
        bit   in_hold;
        int   c;
        n       = m;
        rise    = stp && !m.stepq;
        n.stepq = stp;
        if (!m.started || m.stopped) begin
            if (st) begin
                n.started = 1'b1;
                n.stopped = 1'b0;
                n.es      = 0;
                n.cnt     = 0;
                n.cause   = 0;
                n.en      = 1'b0;
                n.mode    = (md == 2'd3) ? 0 : int'(md);
                n.lim     = (lim_in == 0) ? maxc : lim_in;
            end
        end else begin
            in_hold = (m.es < r);
            if (m.en && m.cnt < maxv) n.cnt = m.cnt + 1;
            c = 0;
            if (abt) c = 3;
            else if (!in_hold && hlt) c = 2;
            else if (!in_hold && m.mode == 1 && n.cnt >= n.lim) c = 1;
            if (c != 0) begin
                n.stopped = 1'b1;
                n.en      = 1'b0;
                n.cause   = c;
            end else begin
                if (m.es < r) n.es = m.es + 1;
                n.en = (n.es >= r) && (m.mode != 2 || (!in_hold && rise));
            end
        end
        return n;
    endfunction

    function automatic bit m_rst(mdl_t m, int r);
        return !m.started || (!m.stopped && m.es < r);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= mdl_step(ma, a_start, a_mode, longint'(a_limit), a_step, a_halt, a_abort,
                           2, 64'd59, 64'd4294967295);
            mb <= mdl_step(mb, b_start, b_mode, longint'(b_limit), b_step, b_halt, b_abort,
                           1, 64'd11, 64'd15);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("a_core_rst", a_core_rst, m_rst(ma, 2));
        chk("a_core_en", a_core_en, ma.en);
        chk("a_cycle_cnt", a_cycle_cnt, ma.cnt);
        chk("a_busy", a_busy, ma.started && !ma.stopped);
        chk("a_done", a_done, ma.stopped);
        chk("a_done_cause", a_done_cause, ma.cause);
        chk("b_core_rst", b_core_rst, m_rst(mb, 1));
        chk("b_core_en", b_core_en, mb.en);
        chk("b_cycle_cnt", b_cycle_cnt, mb.cnt);
        chk("b_busy", b_busy, mb.started && !mb.stopped);
        chk("b_done", b_done, mb.stopped);
        chk("b_done_cause", b_done_cause, mb.cause);
    end

    int en_a = 0, rst_a = 0, en_b = 0, rst_b = 0;

    task automatic tick();
        @(negedge clk);
        if (a_core_en)  en_a++;
        if (a_core_rst) rst_a++;
        if (b_core_en)  en_b++;
        if (b_core_rst) rst_b++;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_core_rst", a_core_rst, 1);
        chk("reset_core_en", a_core_en, 0);
        chk("reset_cnt", a_cycle_cnt, 0);
        chk("reset_done", a_done, 0);

        // Bounded run with limit 0 -> MAX_CYCLES
        a_mode = 2'b01; a_limit = 32'd0; en_a = 0; rst_a = 0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int i = 0; i < 100 && !a_done; i++) tick();
        chk("t1_done", a_done, 1);
        chk("t1_rst_cycles", rst_a, 2);
        chk("t1_en_cycles", en_a, 59);
        chk("t1_cnt", a_cycle_cnt, 59);
        chk("t1_cause", a_done_cause, 1);

        // Free-run, halt on the 10th enabled cycle
        a_mode = 2'b00; en_a = 0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        for (int i = 0; i < 50 && en_a < 10; i++) tick();
        a_halt = 1'b1; tick(); a_halt = 1'b0;
        chk("t2_cnt", a_cycle_cnt, 10);
        chk("t2_cause", a_done_cause, 2);
        repeat (3) tick();
        chk("t2_core_rst_done", a_core_rst, 0);

        // Single step: three step rises, one held for 4 cycles, then halt
        a_mode = 2'b10;
        a_start = 1'b1; tick(); a_start = 1'b0;
        repeat (3) tick();
        en_a = 0;
        a_step = 1'b1; tick(); a_step = 1'b0; repeat (3) tick();
        a_step = 1'b1; repeat (4) tick(); a_step = 1'b0; repeat (3) tick();
        a_step = 1'b1; tick(); a_step = 1'b0; repeat (3) tick();
        a_halt = 1'b1; tick(); a_halt = 1'b0;
        chk("t3_pulses", en_a, 3);
        chk("t3_cnt", a_cycle_cnt, 3);
        chk("t3_cause", a_done_cause, 2);

        // Abort and halt on the same RUN edge
        a_mode = 2'b00;
        a_start = 1'b1; tick(); a_start = 1'b0;
        repeat (5) tick();
        a_abort = 1'b1; a_halt = 1'b1; tick(); a_abort = 1'b0; a_halt = 1'b0;
        chk("t4_cause", a_done_cause, 3);
        chk("t4_cnt", a_cycle_cnt, 4);

        // Abort during reset hold
        en_a = 0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        a_abort = 1'b1; tick(); a_abort = 1'b0;
        repeat (3) tick();
        chk("t4b_done", a_done, 1);
        chk("t4b_cause", a_done_cause, 3);
        chk("t4b_cnt", a_cycle_cnt, 0);
        chk("t4b_en_never", en_a, 0);

        // halt/abort in DONE are ignored
        a_halt = 1'b1; a_abort = 1'b1; tick(); a_halt = 1'b0; a_abort = 1'b0;
        chk("t4c_cause_kept", a_done_cause, 3);

        // Mode 11 behaves as free-run (limit ignored)
        a_mode = 2'b11; a_limit = 32'd3;
        a_start = 1'b1; tick(); a_start = 1'b0;
        repeat (8) tick();
        chk("t4d_busy", a_busy, 1);
        chk("t4d_cnt", a_cycle_cnt, 6);
        a_abort = 1'b1; tick(); a_abort = 1'b0;

        // Asynchronous reset mid-run, then a normal run with ignored starts
        a_mode = 2'b00;
        a_start = 1'b1; tick(); a_start = 1'b0;
        repeat (6) tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_core_rst", a_core_rst, 1);
        chk("t5_core_en", a_core_en, 0);
        chk("t5_cnt", a_cycle_cnt, 0);
        chk("t5_busy", a_busy, 0);
        chk("t5_done", a_done, 0);
        chk("t5_cause", a_done_cause, 0);
        tick();
        rst = 1'b0;
        tick();
        a_mode = 2'b01; a_limit = 32'd5; en_a = 0;
        a_start = 1'b1; tick(); a_start = 1'b0;
        a_mode = 2'b10; a_limit = 32'd1;
        for (int i = 0; i < 30 && !a_done; i++) begin
            a_start = (i == 1 || i == 3);
            tick();
        end
        a_start = 1'b0;
        chk("t5_en_cycles", en_a, 5);
        chk("t5_cnt_run", a_cycle_cnt, 5);
        chk("t5_cause_run", a_done_cause, 1);

        // Narrow counter saturation, then restart with a one-cycle reset hold
        b_mode = 2'b00; en_b = 0;
        b_start = 1'b1; tick(); b_start = 1'b0;
        for (int i = 0; i < 40 && en_b < 20; i++) tick();
        b_abort = 1'b1; tick(); b_abort = 1'b0;
        chk("t6_en_cycles", en_b, 20);
        chk("t6_cnt_sat", b_cycle_cnt, 15);
        chk("t6_cause", b_done_cause, 3);
        rst_b = 0;
        b_start = 1'b1; tick(); b_start = 1'b0;
        chk("t6_restart_cnt", b_cycle_cnt, 0);
        chk("t6_restart_rst", b_core_rst, 1);
        tick();
        chk("t6_rst_released", b_core_rst, 0);
        chk("t6_en_rises", b_core_en, 1);
        chk("t6_rst_cycles", rst_b, 1);
        b_abort = 1'b1; tick(); b_abort = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/run_controller.md
# run_controller

Synthesizable run/reset sequencer that sits between the top-level `clk`/`rst` and the `processor` core. It holds the core in reset for a programmable number of cycles, then grants clock-enabled execution cycles in free-run, bounded or single-step mode. It stops on a cycle limit, a core halt or an external abort, and it reports the executed cycle count and stop cause. It replaces fixed-length bench loops with a reusable, parametrised controller usable in both simulation and FPGA bring-up.

## Interface

Parameters:
- `CNT_W`, default 32: width of the cycle counter and the `limit` input.
- `RST_CYCLES`, default 2: number of cycles `core_rst` is held after `start`. Legal range is ≥1.
- `MAX_CYCLES`, default 59: effective limit used when `limit` is 0.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; sampled in IDLE or DONE only.
- `mode`  in  2  run mode, latched at `start`. 00 = free-run, 01 = bounded, 10 = single-step, 11 = treated as 00.
- `limit`  in  CNT_W  cycle budget for bounded mode, latched at `start`. A value of 0 selects `MAX_CYCLES`.
- `step`  in  1  single-step request; one granted cycle per 0→1 transition.
- `halt`  in  1  halt indication from the core.
- `abort`  in  1  external stop.
- `core_rst`  out  1  reset to the core.
- `core_en`  out  1  registered clock enable to the core.
- `cycle_cnt`  out  CNT_W  number of enabled cycles since the last `start`.
- `busy`  out  1  high in RESET_HOLD, RUN and STEP_WAIT.
- `done`  out  1  high in DONE.
- `done_cause`  out  2  stop cause: 00 = none, 01 = limit, 10 = halt, 11 = abort.

## Operation

- States: IDLE, RESET_HOLD, RUN, STEP_WAIT, DONE.
- Async `rst`: state IDLE, `core_rst`=1, `core_en`=0, `cycle_cnt`=0, `busy`=0, `done`=0, `done_cause`=00, hold counter 0, step edge register 0. Applies from any state, including mid-run.
- IDLE: `core_rst`=1. On `start`: latch `mode` and `limit_eff`, clear `cycle_cnt`, `done` and `done_cause`, load the hold counter with `RST_CYCLES`, and go to RESET_HOLD.
- RESET_HOLD: `core_rst`=1 and the hold counter decrements. When the counter reaches 0, go to STEP_WAIT if the latched mode is 10, otherwise go to RUN.
- RUN: `core_en`=1 and `cycle_cnt` increments on each edge where `core_en`=1, saturating at all-ones. In bounded mode the run ends after exactly `limit_eff` enabled cycles with cause 01. Free-run never ends on a limit.
- STEP_WAIT: `core_en` pulses high for exactly one cycle per detected `step` rising edge. The counter increments on each granted cycle. There is no limit check in this mode.
- Stop priority when several stop conditions occur on one edge: abort > halt > limit.
  - `abort` is honoured in RESET_HOLD, RUN and STEP_WAIT.
  - `halt` is honoured in RUN and STEP_WAIT.
- Stop event: go to DONE, `core_en`=0 on that edge, set `done_cause`. The edge on which the stop is sampled still counts a cycle if `core_en` was 1 during it.
- DONE: `core_rst`=0 so core state is preserved for inspection, `core_en`=0, `done`=1. Holds until `start` (restart) or `rst`.
- `start` while `busy` is ignored. `abort` and `halt` are ignored in IDLE and DONE.
- `busy` and `done` are never both 1.

## Timing

- All outputs are registered; there are no combinational input→output paths.
- Let `start` be sampled at edge k, with R = `RST_CYCLES` and L = `limit_eff`.
  - `busy` rises at k.
  - `core_rst` falls and `core_en` rises at edge k+R.
  - Bounded mode: `core_en` is high for edges k+R .. k+R+L−1. `core_en` falls and `done` rises at k+R+L, with `cycle_cnt`=L.
- Step: `step` rising edge sampled at edge j → `core_en`=1 during cycle j..j+1 only, and `cycle_cnt` increments at j+1.
- Halt: `halt` sampled at edge h in RUN → `core_en` falls at h, `done`=1 and cause 10 from h, and `cycle_cnt` includes the cycle ending at h.

## Test plan

- Defaults, `mode`=01, `limit`=0, `start` pulse after `rst` release → `core_rst` high for 2 cycles after `start`, `core_en` high exactly 59 cycles, `done`=1, `done_cause`=01, `cycle_cnt`=59.
- `mode`=00, `halt` asserted on the 10th enabled cycle → `done_cause`=10, `cycle_cnt`=10, `core_rst` stays 0 in DONE.
- `mode`=10, three `step` pulses (one held high for 4 cycles), then `halt` → exactly 3 `core_en` pulses, `cycle_cnt`=3, `done_cause`=10.
- `abort` and `halt` asserted on the same edge in RUN → `done_cause`=11. Separately, `abort` during RESET_HOLD → DONE, `cycle_cnt`=0, `core_en` never asserted.
- `rst` asserted asynchronously mid-RUN (between edges) → outputs immediately return to reset values. A subsequent `start` runs normally, and `start` pulses while `busy` are ignored.
- `CNT_W`=4, `mode`=00, run 20 cycles then `abort` → `cycle_cnt` saturates at 15. Then `RST_CYCLES`=1 override, restart from DONE → `core_rst` high 1 cycle and `cycle_cnt` cleared.
